// File: rtl/mem_port_arbiter.sv
// Purpose: arbitrates the fetch (I) and load/store (D) requesters onto the single memory port.
// Latency: grant one edge after a request is seen, done one edge after mem_ack; one IDLE cycle between transactions.
// Backpressure: requesters hold a level request until their done pulse; the memory stalls via mem_ack.
// Optional: ARB_TIMEOUT_EN adds an ack watchdog that ends a stalled transaction and sets sticky bus_err.
module mem_port_arbiter #(
    parameter int FAIR    = 1,
    parameter int TIMEOUT = 255
) (
    input  logic        ph1,
    input  logic        reset,
    input  logic        i_req,
    input  logic [31:0] i_adr,
    output logic [31:0] i_rdata,
    output logic        i_done,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_adr,
    input  logic [31:0] d_wdata,
    input  logic [3:0]  d_byteen,
    output logic [31:0] d_rdata,
    output logic        d_done,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_adr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_byteen,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack,
    output logic        bus_err
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2
    } state_t;

    // last_grant encoding: 0 = I owned the port last, 1 = D did
    localparam logic GRANT_I = 1'b0;
    localparam logic GRANT_D = 1'b1;

    // The watchdog counter is 8 bits wide, so the limit must fit in it
    if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_timeout
        $error("mem_port_arbiter: TIMEOUT must be in 1..255");
    end

    state_t      state_q, state_d;
    logic        last_grant_q, last_grant_d;
    logic        mem_req_q, mem_req_d;
    logic        mem_we_q, mem_we_d;
    logic [31:0] mem_adr_q, mem_adr_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;
    logic [3:0]  mem_byteen_q, mem_byteen_d;
    logic [31:0] i_rdata_q, i_rdata_d;
    logic [31:0] d_rdata_q, d_rdata_d;
    logic        i_done_q, i_done_d;
    logic        d_done_q, d_done_d;

    logic        i_pend, d_pend, pick_d;
    logic        fin, fin_upd;
    logic [31:0] fin_dat;

`ifdef ARB_TIMEOUT_EN
    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);
    logic [7:0]  cnt_q, cnt_d;
    logic        bus_err_q, bus_err_d;
`endif

    // Mask a requester whose done is still visible, then pick the winner
    always_comb begin
        i_pend = i_req & ~i_done_q;
        d_pend = d_req & ~d_done_q;
        if (i_pend && d_pend) begin
            pick_d = !((FAIR != 0) && (last_grant_q == GRANT_D));
        end else begin
            pick_d = d_pend;
        end
    end

    // Next-state and registered-output computation
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        mem_req_d    = mem_req_q;
        mem_we_d     = mem_we_q;
        mem_adr_d    = mem_adr_q;
        mem_wdata_d  = mem_wdata_q;
        mem_byteen_d = mem_byteen_q;
        i_rdata_d    = i_rdata_q;
        d_rdata_d    = d_rdata_q;
        i_done_d     = 1'b0;
        d_done_d     = 1'b0;
        fin          = 1'b0;
        fin_upd      = 1'b0;
        fin_dat      = mem_rdata;
`ifdef ARB_TIMEOUT_EN
        cnt_d        = cnt_q;
        bus_err_d    = bus_err_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (i_pend || d_pend) begin
                    mem_req_d = 1'b1;
`ifdef ARB_TIMEOUT_EN
                    cnt_d     = 8'd0;
`endif
                    if (pick_d) begin
                        mem_we_d     = d_we;
                        mem_adr_d    = d_adr;
                        mem_wdata_d  = d_wdata;
                        mem_byteen_d = d_we ? d_byteen : 4'hf;
                        last_grant_d = GRANT_D;
                        state_d      = BUSY_D;
                    end else begin
                        mem_we_d     = 1'b0;
                        mem_adr_d    = i_adr;
                        mem_wdata_d  = 32'h0;
                        mem_byteen_d = 4'hf;
                        last_grant_d = GRANT_I;
                        state_d      = BUSY_I;
                    end
                end
            end
            BUSY_I, BUSY_D: begin
                // Stores leave d_rdata untouched on a normal ack
                fin     = mem_ack;
                fin_upd = (state_q == BUSY_I) || !mem_we_q;
`ifdef ARB_TIMEOUT_EN
                if (!mem_ack) begin
                    if (cnt_q == TMO_LAST) begin
                        fin       = 1'b1;
                        fin_upd   = 1'b1;
                        fin_dat   = 32'hdeadbeef;
                        bus_err_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end
`endif
                if (fin) begin
                    mem_req_d = 1'b0;
                    mem_we_d  = 1'b0;
                    state_d   = IDLE;
                    if (state_q == BUSY_I) begin
                        i_done_d = 1'b1;
                        if (fin_upd) i_rdata_d = fin_dat;
                    end else begin
                        d_done_d = 1'b1;
                        if (fin_upd) d_rdata_d = fin_dat;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers with synchronous reset
    always_ff @(posedge ph1) begin
        if (reset) begin
            state_q      <= IDLE;
            last_grant_q <= GRANT_I;
            mem_req_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_adr_q    <= 32'h0;
            mem_wdata_q  <= 32'h0;
            mem_byteen_q <= 4'h0;
            i_rdata_q    <= 32'h0;
            d_rdata_q    <= 32'h0;
            i_done_q     <= 1'b0;
            d_done_q     <= 1'b0;
`ifdef ARB_TIMEOUT_EN
            cnt_q        <= 8'd0;
            bus_err_q    <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            mem_req_q    <= mem_req_d;
            mem_we_q     <= mem_we_d;
            mem_adr_q    <= mem_adr_d;
            mem_wdata_q  <= mem_wdata_d;
            mem_byteen_q <= mem_byteen_d;
            i_rdata_q    <= i_rdata_d;
            d_rdata_q    <= d_rdata_d;
            i_done_q     <= i_done_d;
            d_done_q     <= d_done_d;
`ifdef ARB_TIMEOUT_EN
            cnt_q        <= cnt_d;
            bus_err_q    <= bus_err_d;
`endif
        end
    end

    assign mem_req    = mem_req_q;
    assign mem_we     = mem_we_q;
    assign mem_adr    = mem_adr_q;
    assign mem_wdata  = mem_wdata_q;
    assign mem_byteen = mem_byteen_q;
    assign i_rdata    = i_rdata_q;
    assign d_rdata    = d_rdata_q;
    assign i_done     = i_done_q;
    assign d_done     = d_done_q;
`ifdef ARB_TIMEOUT_EN
    assign bus_err    = bus_err_q;
`else
    assign bus_err    = 1'b0;
`endif

endmodule
